mult_req_arbiter: RTL and testbench

MULT_REQ_ARBITER -- requirements
Module: mult_req_arbiter

---
 rtl/mult_req_arbiter_pkg.sv | 36 +++
 rtl/mult_req_arbiter_multi4x4.sv | 10 +
 rtl/mult_req_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_req_arbiter_pkg.sv
// Shared constants for the two-requester shift-add multiplier.
// State encodings, display codes and partial-product shift amounts.
package mult_req_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LSB  = 3'd1,
        S_MID1 = 3'd2,
        S_MID2 = 3'd3,
        S_MSB  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [2:0] DISP_IDLE = 3'b000;
    localparam logic [2:0] DISP_LSB  = 3'b001;
    localparam logic [2:0] DISP_MID  = 3'b010;
    localparam logic [2:0] DISP_MSB  = 3'b011;
    localparam logic [2:0] DISP_DONE = 3'b100;

    localparam logic [3:0] SH_LSB = 4'd0;
    localparam logic [3:0] SH_MID = 4'd4;
    localparam logic [3:0] SH_MSB = 4'd8;

    function automatic logic [2:0] disp_code(input state_t s);
        case (s)
            S_IDLE:  disp_code = DISP_IDLE;
            S_LSB:   disp_code = DISP_LSB;
            S_MID1:  disp_code = DISP_MID;
            S_MID2:  disp_code = DISP_MID;
            S_MSB:   disp_code = DISP_MSB;
            S_DONE:  disp_code = DISP_DONE;
            default: disp_code = DISP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mult_req_arbiter_multi4x4.sv
// Combinational 4x4 unsigned multiplier producing one partial product.
module multi4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);

    assign product = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/mult_req_arbiter.sv
// Round-robin arbiter in front of a 4-cycle nibble shift-add 8x8 multiplier.
import mult_req_arbiter_pkg::*;

module mult_req_arbiter (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        busy,
    output logic [2:0]  state_out
);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        id_q;
    logic        last_q;
    logic [15:0] acc;
    logic [15:0] addend;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  sh;
    logic [7:0]  pp;
    logic        acc_en;
    logic        pick0;
    logic        pick1;

    // last_q high means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        pick0 = req0 && (!req1 || last_q);
        pick1 = req1 && !pick0;
    end

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        acc_en   = 1'b0;
        nib_a    = a_q[3:0];
        nib_b    = b_q[3:0];
        sh       = SH_LSB;
        case (state)
            S_IDLE: begin
                if (reset_a && (pick0 || pick1)) begin
                    gnt0     = pick0;
                    gnt1     = pick1;
                    state_nx = S_LSB;
                end
            end
            S_LSB: begin
                acc_en   = 1'b1;
                state_nx = S_MID1;
            end
            S_MID1: begin
                acc_en   = 1'b1;
                nib_a    = a_q[7:4];
                sh       = SH_MID;
                state_nx = S_MID2;
            end
            S_MID2: begin
                acc_en   = 1'b1;
                nib_b    = b_q[7:4];
                sh       = SH_MID;
                state_nx = S_MSB;
            end
            S_MSB: begin
                acc_en   = 1'b1;
                nib_a    = a_q[7:4];
                nib_b    = b_q[7:4];
                sh       = SH_MSB;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done0    = !id_q;
                done1    = id_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    multi4x4 u_pp (
        .a       (nib_a),
        .b       (nib_b),
        .product (pp)
    );

    assign addend = {8'd0, pp} << sh;

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            state  <= S_IDLE;
            acc    <= 16'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                a_q    <= gnt1 ? a1 : a0;
                b_q    <= gnt1 ? b1 : b0;
                id_q   <= gnt1;
                last_q <= gnt1;
                acc    <= 16'd0;
            end else if (acc_en) begin
                acc <= acc + addend;
            end
        end
    end

    // The accumulator only changes after a grant, so it doubles as the held result
    assign result    = acc;
    assign busy      = (state != S_IDLE);
    assign state_out = disp_code(state);

endmodule

// File: tb/tb_mult_req_arbiter.sv
// Scoreboard bench: cycle-level reference model predicts grants and results.
module tb_mult_req_arbiter;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        req0;
    logic        req1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] result;
    logic        busy;
    logic [2:0]  state_out;

    always #5 clk = ~clk;

    mult_req_arbiter dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .busy      (busy),
        .state_out (state_out)
    );

    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;

    exp_t q[$];
    int   gnt_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 0;

    // Model: cycles left until idle, who was served last, held result
    int cnt = 0;
    int last = 1;
    int cur_prod = 0;
    int last_result = 0;
    bit drop0 = 0;
    bit drop1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int disp(input int c);
        case (c)
            5:       return 1;
            4, 3:    return 2;
            2:       return 3;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_eval();
        int   eg0;
        int   eg1;
        exp_t e;
        eg0 = 0;
        eg1 = 0;
        if (reset_a && cnt == 0) begin
            if (req0 && (!req1 || last == 1)) eg0 = 1;
            else if (req1) eg1 = 1;
        end
        check("gnt0", int'(gnt0), eg0);
        check("gnt1", int'(gnt1), eg1);
        check("busy", int'(busy), (cnt > 0) ? 1 : 0);
        check("state_out", int'(state_out), disp(cnt));
        if (cnt == 0) check("held_result", int'(result), last_result);
        if (eg0 || eg1) begin
            e.id   = eg1;
            e.prod = eg1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
            e.due  = cyc + 5;
            q.push_back(e);
            cur_prod = e.prod;
            last = eg1;
            if (eg0) drop0 = 1;
            if (eg1) drop1 = 1;
        end
        if (!reset_a) begin
            cnt = 0;
            last = 1;
            last_result = 0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (eg0 || eg1) begin
            cnt = 5;
        end else if (cnt > 0) begin
            if (cnt == 1) last_result = cur_prod;
            cnt--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        if (drop0) req0 = 1'b0;
        if (drop1) req1 = 1'b0;
        drop0 = 0;
        drop1 = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cnt != 0 || req0 || req1) && n < 30) begin
            tick();
            n++;
        end
        check("idle_timeout", n, (n < 30) ? n : 0);
    endtask

    task automatic do_reset();
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT reports completion
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (gnt0 && gnt1) check("gnt_overlap", 1, 0);
            if (done0 && done1) check("done_overlap", 1, 0);
            if (gnt0 || gnt1) gnt_log.push_back(gnt1 ? 1 : 0);
            if (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                check("missed_done", 0, 1);
            end
            if (done0 || done1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_id", done1 ? 1 : 0, e.id);
                    check("done_cycle", cyc, e.due);
                    check("result", int'(result), e.prod);
                end
            end
        end
    end

    initial begin
        reset_a = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = 8'd0;
        b0 = 8'd0;
        a1 = 8'd0;
        b1 = 8'd0;
        @(posedge clk);
        #1;
        started = 1;
        tick();
        tick();
        reset_a = 1'b1;
        repeat (2) tick();

        // Lone requester 0 and lone requester 1 at full scale
        a0 = 8'd29; b0 = 8'd7; req0 = 1'b1;
        wait_idle();
        repeat (2) tick();
        check("r024_result", int'(result), 203);
        a1 = 8'd255; b1 = 8'd255; req1 = 1'b1;
        wait_idle();
        repeat (2) tick();
        check("r025_result", int'(result), 65025);

        // Simultaneous requests after reset: 0 first, then 1
        do_reset();
        a0 = 8'd3; b0 = 8'd4; a1 = 8'd10; b1 = 8'd10;
        req0 = 1'b1; req1 = 1'b1;
        wait_idle();
        repeat (2) tick();
        check("r026_result", int'(result), 100);

        // Continuous contention: grants must alternate
        do_reset();
        gnt_log.delete();
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 40 && gnt_log.size() < 4; n++) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            tick();
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("alt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("alt_order", gnt_log[i], i % 2);
        wait_idle();

        // Reset while in MID1 aborts without a done pulse
        a0 = 8'd200; b0 = 8'd99; req0 = 1'b1;
        tick();
        tick();
        check("mid1_state", int'(state_out), 2);
        do_reset();
        check("abort_state", int'(state_out), 0);
        check("abort_result", int'(result), 0);
        check("abort_busy", int'(busy), 0);
        repeat (6) tick();

        // Operand changes while busy must not disturb the operation
        a0 = 8'd16; b0 = 8'd16; req0 = 1'b1;
        tick();
        for (int n = 0; n < 6; n++) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            tick();
        end
        check("r029_result", int'(result), 256);

        // Randomized traffic, including withdrawn requests and rare resets
        for (int n = 0; n < 600; n++) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
            else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
            if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
            else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
            reset_a = ($urandom_range(99) != 0);
            tick();
        end
        reset_a = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) tick();
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
